// File: rtl/kernel_stream_pkg.sv
// kernel_stream_pkg: shared encodings and width helpers for the kernel stream block.
package kernel_stream_pkg;

   // Second-stage operator encodings
   localparam int unsigned KS_MODE_ADD = 0;
   localparam int unsigned KS_MODE_MUL = 1;

   // Width of a counter that must hold 0..depth inclusive
   function automatic int unsigned ks_occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/kernel_stream_fifo.sv
// kernel_stream_fifo: first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module kernel_stream_fifo
   import kernel_stream_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CntW = ks_occ_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_valid,
   output logic [CntW-1:0]  o_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [CntW-1:0]  r_count;
   logic             w_rd;

   // A read only happens when there is a head entry to pop
   assign w_rd      = i_rd_en && (r_count != '0);
   assign o_valid   = (r_count != '0);
   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Storage array: written at the tail, never reset
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers and count; simultaneous write and read leave the count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         unique case ({i_wr_en, w_rd})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/kernel_stream_top.sv
// kernel_stream_top: multi-lane two-stage kernel (local1 = vin0 + vin1, vout = f(local1, local1))
// behind a valid/ready stream interface with a credit-guarded output FIFO.
// Define KERNEL_STREAM_SAT_EN for unsigned saturating arithmetic and a live sat_hit flag;
// otherwise both stages wrap and sat_hit is tied low.
module kernel_stream_top
   import kernel_stream_pkg::*;
#(
   parameter int unsigned DATAW      = 32,
   parameter int unsigned LANES      = 1,
   parameter int unsigned MODE       = KS_MODE_ADD,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*DATAW-1:0] ka_vin0,
   input  logic [LANES*DATAW-1:0] ka_vin1,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*DATAW-1:0] ka_vout,
   output logic                   sat_hit
);

   localparam int unsigned OccW  = ks_occ_width(FIFO_DEPTH);
   localparam int unsigned LaneW = LANES * DATAW;

   logic                        w_in_ready;
   logic                        w_in_fire;
   logic                        w_fifo_wr;
   logic [OccW-1:0]             w_fifo_count;
   logic [OccW-1:0]             w_occ;
   logic                        r_s1_valid;
   logic                        r_s2_valid;
   logic [LANES-1:0][DATAW-1:0] r_s1_data;
   logic [LANES-1:0][DATAW-1:0] r_s2_data;
   logic [LANES-1:0][DATAW-1:0] w_s1_d;
   logic [LANES-1:0][DATAW-1:0] w_s2_d;
`ifdef KERNEL_STREAM_SAT_EN
   logic [LANES-1:0]            w_s1_ovf;
   logic [LANES-1:0]            w_s2_ovf;
   logic                        r_s1_sat;
   logic                        r_sat_hit;
`endif

   // Every accepted beat holds a credit until it leaves the FIFO, so occ never exceeds depth
   assign w_occ      = OccW'(r_s1_valid) + OccW'(r_s2_valid) + w_fifo_count;
   assign w_in_ready = !rst && !stall && (w_occ < OccW'(FIFO_DEPTH));
   assign w_in_fire  = in_valid && w_in_ready;
   assign w_fifo_wr  = !stall && r_s2_valid;
   assign in_ready   = w_in_ready;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [DATAW-1:0] w_a;
      logic [DATAW-1:0] w_b;
      assign w_a = ka_vin0[g*DATAW +: DATAW];
      assign w_b = ka_vin1[g*DATAW +: DATAW];
`ifdef KERNEL_STREAM_SAT_EN
      logic [DATAW:0] w_sum;
      assign w_sum       = {1'b0, w_a} + {1'b0, w_b};
      assign w_s1_ovf[g] = w_sum[DATAW];
      assign w_s1_d[g]   = w_sum[DATAW] ? '1 : w_sum[DATAW-1:0];
      if (MODE == KS_MODE_MUL) begin : g_mul
         logic [2*DATAW-1:0] w_prod;
         assign w_prod      = {{DATAW{1'b0}}, r_s1_data[g]} * {{DATAW{1'b0}}, r_s1_data[g]};
         assign w_s2_ovf[g] = |w_prod[2*DATAW-1:DATAW];
         assign w_s2_d[g]   = w_s2_ovf[g] ? '1 : w_prod[DATAW-1:0];
      end else begin : g_add
         logic [DATAW:0] w_dbl;
         assign w_dbl       = {1'b0, r_s1_data[g]} + {1'b0, r_s1_data[g]};
         assign w_s2_ovf[g] = w_dbl[DATAW];
         assign w_s2_d[g]   = w_dbl[DATAW] ? '1 : w_dbl[DATAW-1:0];
      end
`else
      assign w_s1_d[g] = w_a + w_b;
      if (MODE == KS_MODE_MUL) begin : g_mul
         assign w_s2_d[g] = r_s1_data[g] * r_s1_data[g];
      end else begin : g_add
         assign w_s2_d[g] = r_s1_data[g] + r_s1_data[g];
      end
`endif
   end

   // Stage valid bits advance together unless stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else if (!stall) begin
         r_s1_valid <= w_in_fire;
         r_s2_valid <= r_s1_valid;
      end
   end

   // Stage data registers hold during stall; not reset
   always_ff @(posedge clk) begin
      if (!stall) begin
         r_s1_data <= w_s1_d;
         r_s2_data <= w_s2_d;
      end
   end

`ifdef KERNEL_STREAM_SAT_EN
   // Stage-1 saturation marker travels alongside the S1 data
   always_ff @(posedge clk) begin
      if (!stall) begin
         r_s1_sat <= |w_s1_ovf;
      end
   end

   // Sticky flag raised when S2 captures a beat that saturated in either stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat_hit <= 1'b0;
      end else if (!stall && r_s1_valid && (r_s1_sat || (|w_s2_ovf))) begin
         r_sat_hit <= 1'b1;
      end
   end

   assign sat_hit = r_sat_hit;
`else
   assign sat_hit = 1'b0;
`endif

   kernel_stream_fifo #(
      .WIDTH (LaneW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_fifo_wr),
      .i_wr_data (r_s2_data),
      .i_rd_en   (out_ready),
      .o_rd_data (ka_vout),
      .o_valid   (out_valid),
      .o_count   (w_fifo_count)
   );

endmodule

// File: tb/tb_kernel_stream_top.sv
// tb_kernel_stream_top: randomized and directed checks of kernel_stream_top against a
// transaction-level model (per-beat arithmetic plus an in-order expected-result queue).
// Honors KERNEL_STREAM_SAT_EN to pick saturating or wrapping expectations.
module tb_kernel_stream_top;

   localparam int DATAW      = 8;
   localparam int LANES      = 4;
   localparam int MODE       = 1;
   localparam int FIFO_DEPTH = 4;
   localparam int LW         = LANES * DATAW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [LW-1:0] ka_vin0 = '0;
   logic [LW-1:0] ka_vin1 = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [LW-1:0] ka_vout;
   logic          sat_hit;

   int            n_vec = 0;
   int            n_err = 0;
   int            outstanding = 0;
   int            n_pop = 0;
   int            n_acc = 0;
   bit            sticky = 0;
   bit            saw_block = 0;
   logic [LW-1:0] q_exp[$];
   bit            q_sat[$];

   kernel_stream_top #(
      .DATAW      (DATAW),
      .LANES      (LANES),
      .MODE       (MODE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ka_vin0   (ka_vin0),
      .ka_vin1   (ka_vin1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ka_vout   (ka_vout),
      .sat_hit   (sat_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Per-lane arithmetic on true integer values, then clamp or wrap
   function automatic logic [LW-1:0] model_beat(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                                output bit sat);
      longint unsigned mx, s1, r;
      logic [LW-1:0]   res;
      mx  = (longint'(1) << DATAW) - 1;
      sat = 0;
      res = '0;
      for (int i = 0; i < LANES; i++) begin
         s1 = longint'(a[i*DATAW +: DATAW]) + longint'(b[i*DATAW +: DATAW]);
`ifdef KERNEL_STREAM_SAT_EN
         if (s1 > mx) begin s1 = mx; sat = 1; end
`else
         s1 = s1 % (mx + 1);
`endif
         r = (MODE == 1) ? s1 * s1 : s1 + s1;
`ifdef KERNEL_STREAM_SAT_EN
         if (r > mx) begin r = mx; sat = 1; end
`else
         r = r % (mx + 1);
`endif
         res[i*DATAW +: DATAW] = r[DATAW-1:0];
      end
      return res;
   endfunction

   // One clock: drive at negedge, evaluate handshakes just after, update the model
   task automatic step(input bit r, input bit s, input bit iv, input bit ordy,
                       input logic [LW-1:0] a, input logic [LW-1:0] b);
      logic [LW-1:0] e;
      bit            es;
      bit            er;
      @(negedge clk);
      rst = r; stall = s; in_valid = iv; out_ready = ordy; ka_vin0 = a; ka_vin1 = b;
      #1;
      er = !r && !s && (outstanding < FIFO_DEPTH);
      chk("in_ready", in_ready, er);
      if (!r && !s && outstanding == FIFO_DEPTH && in_ready === 1'b0) saw_block = 1;
      if (r) begin
         q_exp.delete();
         q_sat.delete();
         outstanding = 0;
         sticky = 0;
      end else begin
`ifndef KERNEL_STREAM_SAT_EN
         chk("sat_hit_off", sat_hit, 0);
`endif
         if (out_valid === 1'b1) begin
            chk("ov_has_data", q_exp.size() != 0, 1);
            if (ordy && q_exp.size() != 0) begin
               e  = q_exp.pop_front();
               es = q_sat.pop_front();
               chk("ka_vout", ka_vout, e);
               n_pop++;
               outstanding--;
               sticky |= es;
`ifdef KERNEL_STREAM_SAT_EN
               if (sticky) chk("sat_hit_on", sat_hit, 1);
`endif
            end
         end
         if (iv && in_ready === 1'b1) begin
            e = model_beat(a, b, es);
            q_exp.push_back(e);
            q_sat.push_back(es);
            outstanding++;
            n_acc++;
         end
      end
   endtask

   // Single beat into an empty pipeline; result must appear exactly 3 + ns cycles later
   task automatic lat_test(input logic [LW-1:0] a, input logic [LW-1:0] b, input int ns);
      step(0, 0, 1, 0, a, b);
      for (int k = 0; k < ns; k++) begin
         step(0, 1, 0, 0, '0, '0);
         chk("stall_ov", out_valid, 0);
      end
      step(0, 0, 0, 0, '0, '0);
      chk("lat_early1", out_valid, 0);
      step(0, 0, 0, 0, '0, '0);
      chk("lat_early2", out_valid, 0);
      step(0, 0, 0, 0, '0, '0);
      chk("lat_due", out_valid, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && outstanding > 0; k++) step(0, 0, 0, 1, '0, '0);
      chk("drained", outstanding, 0);
   endtask

   initial begin
      logic [LW-1:0] a;
      logic [LW-1:0] b;

      // Reset
      step(1, 0, 0, 0, '0, '0);
      step(1, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, '0, '0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sat_hit", sat_hit, 0);

      // Lane-ordered multiply: (1,1) (2,3) (0,0) (10,5) -> 4 25 0 225
      a = {8'd10, 8'd0, 8'd2, 8'd1};
      b = {8'd5, 8'd0, 8'd3, 8'd1};
      lat_test(a, b, 0);
      chk("tp_mul_lanes", ka_vout, 32'hE1001904);
      step(0, 0, 0, 1, '0, '0);

      // Overflow in stage 1: 200 + 100 on every lane
      a = {4{8'd200}};
      b = {4{8'd100}};
      lat_test(a, b, 0);
`ifdef KERNEL_STREAM_SAT_EN
      chk("wrap_val", ka_vout, 32'hFFFFFFFF);
`else
      chk("wrap_val", ka_vout, 32'h90909090);
`endif
      step(0, 0, 0, 1, '0, '0);
      step(0, 0, 0, 0, '0, '0);
`ifdef KERNEL_STREAM_SAT_EN
      chk("sat_sticky", sat_hit, 1);
`else
      chk("sat_sticky", sat_hit, 0);
`endif

      // Stall for 3 cycles right after acceptance
      lat_test($urandom, $urandom, 3);
      step(0, 0, 0, 1, '0, '0);

      // Back-pressure: 20 beats, downstream blocked for cycles 5..14
      n_pop = 0;
      n_acc = 0;
      saw_block = 0;
      for (int k = 0; k < 200 && (n_acc < 20 || outstanding > 0); k++) begin
         step(0, 0, n_acc < 20, !(k >= 5 && k <= 14), $urandom, $urandom);
      end
      chk("bp_accepted", n_acc, 20);
      chk("bp_delivered", n_pop, 20);
      chk("bp_blocked", saw_block, 1);

      // Reset with 3 beats in flight
      step(0, 0, 1, 0, {4{8'd250}}, {4{8'd9}});
      step(0, 0, 1, 0, $urandom, $urandom);
      step(0, 0, 1, 0, $urandom, $urandom);
      step(1, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, '0, '0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sat_hit", sat_hit, 0);
      lat_test({8'd7, 8'd6, 8'd5, 8'd4}, {8'd1, 8'd2, 8'd3, 8'd4}, 0);
      chk("midrst_fresh", ka_vout, {8'd64, 8'd64, 8'd64, 8'd64});
      step(0, 0, 0, 1, '0, '0);

      // Randomized traffic with stalls, back-pressure and occasional reset
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom, $urandom);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
